pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Owns the program counter register of the pipelined CPU and decides each cycle which next-PC source the fetch stage takes: sequential fall-through, branch target, jump target or register (jr) target. Sits between the hazard unit (stall), the decode-stage redirect logic (branch/jump/jr requests) and the instruction memory address. A redirect that arrives while fetch is stalled is buffered and applied when the stall releases, so no redirect is lost.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit freeze of the fetch stage; PC must hold while high.
- br_take  input  1  single-cycle pulse: branch taken.
- br_target  input  32  branch target, valid with br_take.
- j_take  input  1  single-cycle pulse: j/jal.
- j_target  input  32  jump target, valid with j_take.
- jr_take  input  1  single-cycle pulse: jr/jalr.
- jr_target  input  32  register target, valid with jr_take.
- pc  output  32  current fetch address (registered).
- pc_plus4  output  32  pc + 4, combinational.
- pc_sel  output  2  source of the PC update this cycle: 0 fall-through, 1 branch, 2 jump, 3 register.
- redirect_pending  output  1  high while a buffered redirect waits for stall release (registered).
- misalign  output  1  registered one-cycle flag, see Configuration.

## Operation
- Request arbitration when several take inputs are high in one cycle: jr_take > j_take > br_take; lower-priority requests in that cycle are discarded.
- Two-state FSM: RUN, PEND.
- RUN, stall=0, request present: pc <= selected target; pc_sel = request code.
- RUN, stall=0, no request: pc <= pc_plus4; pc_sel = 0.
- RUN, stall=1, request present: pc holds; target and code latched into pending buffer; next state PEND.
- RUN, stall=1, no request: pc holds; pc_sel = 0.
- PEND, stall=1: pc holds; a new request overwrites the pending buffer (latest wins); stays PEND.
- PEND, stall=0, no new request: pc <= pending target; pc_sel = pending code; next state RUN.
- PEND, stall=0, new request same cycle: new request wins, pending discarded; pc <= new target; next state RUN.
- pc_sel is combinational from current state and inputs; it reports the source applied at the coming edge, 0 whenever pc holds without replay.
- Arithmetic: pc_plus4 is 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000. Targets are used unmodified (no sign extension, no masking).

## Timing
- Reset (sampled on rising clk while reset=1): pc = RESET_PC, state RUN, pending buffer cleared to 0, redirect_pending = 0, misalign = 0; reset overrides stall and all requests.
- Reset asserted in PEND: buffered redirect discarded; first fetch after reset is RESET_PC.
- Redirect latency: request sampled at edge N appears on pc after edge N when stall=0; when stalled, after the first edge with stall=0.
- redirect_pending rises the cycle after the buffering edge, falls the cycle after replay.
- pc_plus4 tracks pc combinationally, zero cycles.

## Configuration
- PC_ALIGN_CHECK_EN defined: any accepted request whose target[1:0] != 0 is rejected: it is neither applied nor buffered; pc behaves as if no request were present that cycle (fall-through or hold; a still-pending redirect remains valid); misalign is high for exactly the following cycle.
- PC_ALIGN_CHECK_EN undefined: targets used as given; misalign tied to 0.

## Test plan
- Reset with RESET_PC default, no requests, stall=0 for 3 cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; pc_sel=0.
- pc=0x3010, j_take with 0x3400 and br_take with 0x3100 same cycle, stall=0 -> pc=0x3400 next cycle, pc_sel=2 during request.
- stall=1 for 3 cycles, br_take 0x3200 in first stalled cycle -> pc holds, redirect_pending=1; stall drops -> pc=0x3200, redirect_pending=0 one cycle later.
- In PEND with pending 0x3200, jr_take 0x3500 while stall=1, then stall=0 -> pc=0x3500; same with jr_take coinciding with stall release -> pc=0x3500.
- pc=0xFFFF_FFFC, no request -> pc=0x0000_0000; reset asserted while PEND -> pc=0x3000, redirect_pending=0.
- With PC_ALIGN_CHECK_EN, br_take target 0x3102 at pc=0x3020, stall=0 -> pc=0x3024, misalign=1 for one cycle; without macro -> pc=0x3102, misalign=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the program counter of the pipelined CPU. Each cycle it picks the
//   next-PC source for fetch: fall-through, branch, jump or register target.
//   A redirect that arrives while fetch is stalled is buffered and is applied
//   on the first unstalled edge, so no redirect is lost.
//
// Configuration macro:
//   PC_ALIGN_CHECK_EN - when defined, requests whose target[1:0] != 0 are
//                       rejected and flagged on misalign for one cycle.
//                       When undefined, misalign is tied to 0.
//
// Ports:
//   clk              in   1   system clock, rising edge
//   reset            in   1   synchronous, active-high reset
//   stall            in   1   hazard-unit freeze of fetch; pc holds while high
//   br_take          in   1   branch-taken pulse
//   br_target        in  32   branch target
//   j_take           in   1   j/jal pulse
//   j_target         in  32   jump target
//   jr_take          in   1   jr/jalr pulse
//   jr_target        in  32   register target
//   pc               out 32   current fetch address (registered)
//   pc_plus4         out 32   pc + 4 (combinational, modulo 2^32)
//   pc_sel           out  2   source applied at the coming edge
//                             (0 fall-through/hold, 1 branch, 2 jump, 3 jr)
//   redirect_pending out  1   a buffered redirect awaits stall release
//   misalign         out  1   one-cycle flag for a rejected misaligned target

module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_take,
   input  logic [31:0] br_target,
   input  logic        j_take,
   input  logic [31:0] j_target,
   input  logic        jr_take,
   input  logic [31:0] jr_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [1:0]  pc_sel,
   output logic        redirect_pending,
   output logic        misalign
);

   typedef enum logic [0:0] {RUN = 1'b0, PEND = 1'b1} state_t;

   localparam logic [1:0] SEL_SEQ = 2'd0;
   localparam logic [1:0] SEL_BR  = 2'd1;
   localparam logic [1:0] SEL_J   = 2'd2;
   localparam logic [1:0] SEL_JR  = 2'd3;

   state_t      state, state_next;
   logic [31:0] pend_target, pend_target_next;
   logic [1:0]  pend_code, pend_code_next;
   logic [31:0] pc_next;

   logic        req_valid;
   logic [1:0]  req_code;
   logic [31:0] req_target;
   logic        reject;
   logic        accept;

   assign pc_plus4         = pc + 32'd4;
   assign redirect_pending = (state == PEND);

   // Fixed priority jr > j > br; losers in the same cycle are dropped.
   always_comb begin
      req_valid  = 1'b1;
      req_code   = SEL_SEQ;
      req_target = 32'h0;
      if (jr_take) begin
         req_code   = SEL_JR;
         req_target = jr_target;
      end else if (j_take) begin
         req_code   = SEL_J;
         req_target = j_target;
      end else if (br_take) begin
         req_code   = SEL_BR;
         req_target = br_target;
      end else begin
         req_valid  = 1'b0;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   assign reject = req_valid && (req_target[1:0] != 2'b00);
`else
   assign reject = 1'b0;
`endif

   // A rejected request behaves exactly like no request at all.
   assign accept = req_valid && !reject;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned, which would infer a latch.
      state_next       = state;
      pend_target_next = pend_target;
      pend_code_next   = pend_code;
      pc_next          = pc;
      pc_sel           = SEL_SEQ;

      if (stall) begin
         // Fetch frozen: buffer the latest accepted request.
         if (accept) begin
            state_next       = PEND;
            pend_target_next = req_target;
            pend_code_next   = req_code;
         end
      end else if (accept) begin
         // A fresh request supersedes anything still pending.
         pc_next    = req_target;
         pc_sel     = req_code;
         state_next = RUN;
      end else if (state == PEND) begin
         pc_next    = pend_target;
         pc_sel     = pend_code;
         state_next = RUN;
      end else begin
         pc_next    = pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         pc          <= RESET_PC;
         state       <= RUN;
         pend_target <= 32'h0;
         pend_code   <= SEL_SEQ;
      end else begin
         pc          <= pc_next;
         state       <= state_next;
         pend_target <= pend_target_next;
         pend_code   <= pend_code_next;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         misalign <= 1'b0;
      end else begin
         misalign <= reject;
      end
   end
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer: directed scenarios followed by
//   randomized traffic, compared against a behavioural model of the PC
//   and its one-entry redirect buffer.

module tb_pc_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        br_take, j_take, jr_take;
   logic [31:0] br_target, j_target, jr_target;
   logic [31:0] pc, pc_plus4;
   logic [1:0]  pc_sel;
   logic        redirect_pending, misalign;

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   logic [31:0] m_pc;
   bit          m_pend;
   logic [31:0] m_pend_tgt;
   logic [1:0]  m_pend_code;
   bit          m_mis;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(RESET_PC)) dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .br_take          (br_take),
      .br_target        (br_target),
      .j_take           (j_take),
      .j_target         (j_target),
      .jr_take          (jr_take),
      .jr_target        (jr_target),
      .pc               (pc),
      .pc_plus4         (pc_plus4),
      .pc_sel           (pc_sel),
      .redirect_pending (redirect_pending),
      .misalign         (misalign)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check combinational outputs, clock,
   // advance the model, check registered outputs.
   task automatic step(input bit rst, input bit stl,
                       input bit br, input logic [31:0] bt,
                       input bit j,  input logic [31:0] jt,
                       input bit jr, input logic [31:0] jrt);
      bit          any, bad, acc;
      logic [1:0]  code;
      logic [31:0] tgt;
      logic [1:0]  exp_sel;

      reset = rst; stall = stl;
      br_take = br; br_target = bt;
      j_take = j;   j_target = jt;
      jr_take = jr; jr_target = jrt;

      any  = jr || j || br;
      code = jr ? 2'd3 : (j ? 2'd2 : (br ? 2'd1 : 2'd0));
      tgt  = jr ? jrt  : (j ? jt   : (br ? bt   : 32'h0));
`ifdef PC_ALIGN_CHECK_EN
      bad  = any && (tgt % 4 != 0);
`else
      bad  = 1'b0;
`endif
      acc  = any && !bad;

      if (stl)         exp_sel = 2'd0;
      else if (acc)    exp_sel = code;
      else if (m_pend) exp_sel = m_pend_code;
      else             exp_sel = 2'd0;

      #1;
      if (!rst) begin
         check("pc_sel", {30'd0, pc_sel}, {30'd0, exp_sel});
         check("pc_plus4", pc_plus4, m_pc + 32'd4);
      end

      if (rst) begin
         m_pc = RESET_PC; m_pend = 0; m_pend_tgt = 0; m_pend_code = 0; m_mis = 0;
      end else begin
         m_mis = bad;
         if (stl) begin
            if (acc) begin
               m_pend = 1; m_pend_tgt = tgt; m_pend_code = code;
            end
         end else begin
            if (acc)         m_pc = tgt;
            else if (m_pend) m_pc = m_pend_tgt;
            else             m_pc = m_pc + 32'd4;
            m_pend = 0;
         end
      end

      @(posedge clk);
      #1;
      check("pc", pc, m_pc);
      check("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
      check("misalign", {31'd0, misalign}, {31'd0, m_mis});
   endtask

   task automatic idle(input bit stl);
      step(0, stl, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      m_pc = RESET_PC; m_pend = 0; m_pend_tgt = 0; m_pend_code = 0; m_mis = 0;
      reset = 1; stall = 0;
      br_take = 0; j_take = 0; jr_take = 0;
      br_target = 0; j_target = 0; jr_target = 0;
      @(negedge clk);

      // Reset then fall-through: 3000, 3004, 3008, 300C, 3010.
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("reset_pc_const", pc, 32'h0000_3000);
      repeat (4) idle(0);
      check("fallthrough_3010", pc, 32'h0000_3010);

      // Jump beats branch in the same cycle.
      step(0, 0, 1, 32'h3100, 1, 32'h3400, 0, 0);
      check("j_over_br", pc, 32'h0000_3400);

      // Branch during stall is buffered and replayed on release.
      step(0, 1, 1, 32'h3200, 0, 0, 0, 0);
      idle(1); idle(1);
      check("pend_hold_pc", pc, 32'h0000_3400);
      idle(0);
      check("replay_3200", pc, 32'h0000_3200);

      // Newer jr overwrites buffered branch while stalled.
      step(0, 1, 1, 32'h3200, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 32'h3500);
      idle(0);
      check("overwrite_3500", pc, 32'h0000_3500);

      // jr arriving with stall release wins over pending branch.
      step(0, 1, 1, 32'h3200, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 32'h3500);
      check("release_jr_3500", pc, 32'h0000_3500);
      idle(0);

      // Wrap-around of pc + 4.
      step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      idle(0);
      check("wrap_zero", pc, 32'h0000_0000);

      // Reset while pending discards the buffered redirect.
      step(0, 1, 1, 32'h3200, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 32'h4000, 0, 0);
      idle(0);

      // Misaligned branch target.
      step(0, 0, 0, 0, 1, 32'h3020, 0, 0);
      step(0, 0, 1, 32'h3102, 0, 0, 0, 0);
      idle(0);
      // Misaligned request during pending leaves the buffer intact.
      step(0, 1, 1, 32'h3200, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 32'h3501);
      step(0, 0, 0, 0, 1, 32'h3603, 0, 0);
      idle(0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] t0, t1, t2;
         bit rst, stl, b, jj, r;
         t0 = $urandom; t1 = $urandom; t2 = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            t0[1:0] = 2'b00; t1[1:0] = 2'b00; t2[1:0] = 2'b00;
         end
         rst = ($urandom_range(0, 49) == 0);
         stl = ($urandom_range(0, 1) == 1);
         b   = ($urandom_range(0, 3) == 0);
         jj  = ($urandom_range(0, 4) == 0);
         r   = ($urandom_range(0, 5) == 0);
         step(rst, stl, b, t0, jj, t1, r, t2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
